// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package boot_pkg;

  typedef enum logic [2:0] {
    CNT_HI,
    CNT_LO,
    DATA,
    WRITE,
    CSUM,
    DONE,
    ERR
  } boot_state_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned CNT_W      = 16;
  localparam int unsigned IDX_W      = $clog2(WORD_BYTES);

endpackage

// File: rtl/imem_boot_loader_byte_packer.sv
// Assembles big-endian stream bytes into one instruction word.
module byte_packer
  import boot_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_clear,
  input  logic                    i_shift,
  input  logic [7:0]              i_byte,
  output logic [8*WORD_BYTES-1:0] o_word,
  output logic [IDX_W-1:0]        o_idx,
  output logic                    o_word_full
);

  logic [8*WORD_BYTES-1:0] r_word;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_word_full;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_word      <= '0;
      r_idx       <= '0;
      r_word_full <= 1'b0;
    end else if (i_shift) begin
      // First byte ends up in the top byte after WORD_BYTES shifts.
      r_word <= {r_word[8*WORD_BYTES-9:0], i_byte};
      r_idx  <= r_idx + IDX_W'(1);
      if (r_idx == IDX_W'(WORD_BYTES - 1))
        r_word_full <= 1'b1;
    end
  end

  assign o_word      = r_word;
  assign o_idx       = r_idx;
  assign o_word_full = r_word_full;

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a framed byte stream into instruction memory and holds the CPU in
// reset until the image checksum verifies.
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_err
);

  localparam logic [CNT_W:0] MAX_WORDS = (CNT_W + 1)'(1) << ADDR_W;

  boot_state_e       r_state;
  boot_state_e       w_next;
  logic [7:0]        r_cnt_hi;
  logic [CNT_W-1:0]  r_remain;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_xor;

  logic              w_accept;
  logic [CNT_W-1:0]  w_count;
  logic [31:0]       w_word;
  logic [IDX_W-1:0]  w_idx;
  logic              w_word_full;

  assign w_accept = rx_valid & rx_ready;
  assign w_count  = {r_cnt_hi, rx_data};

  byte_packer u_packer (
    .i_clk       (CLK),
    .i_reset     (Reset),
    .i_clear     (r_state == WRITE),
    .i_shift     (w_accept && (r_state == DATA)),
    .i_byte      (rx_data),
    .o_word      (w_word),
    .o_idx       (w_idx),
    .o_word_full (w_word_full)
  );

  always_ff @(posedge CLK) begin
    if (Reset) r_state <= CNT_HI;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      CNT_HI: if (w_accept) w_next = CNT_LO;
      CNT_LO: if (w_accept) begin
        if ({1'b0, w_count} > MAX_WORDS) w_next = ERR;
        else if (w_count == '0)          w_next = CSUM;
        else                             w_next = DATA;
      end
      DATA:   if (w_accept && (w_idx == IDX_W'(WORD_BYTES - 1))) w_next = WRITE;
      WRITE:  w_next = (r_remain == CNT_W'(1)) ? CSUM : DATA;
      CSUM:   if (w_accept) w_next = (rx_data == r_xor) ? DONE : ERR;
      DONE:   w_next = DONE;
      ERR:    w_next = ERR;
      default: w_next = ERR;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_cnt_hi <= '0;
      r_remain <= '0;
      r_addr   <= ADDR_W'(BASE_ADDR);
      r_xor    <= '0;
    end else begin
      if (w_accept && (r_state == CNT_HI || r_state == CNT_LO || r_state == DATA))
        r_xor <= r_xor ^ rx_data;
      case (r_state)
        CNT_HI: if (w_accept) r_cnt_hi <= rx_data;
        CNT_LO: if (w_accept) r_remain <= w_count;
        WRITE: begin
          r_addr   <= r_addr + ADDR_W'(1);
          r_remain <= r_remain - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Every output is decoded from registered state only.
  assign rx_ready   = (r_state == CNT_HI) || (r_state == CNT_LO) ||
                      (r_state == DATA)   || (r_state == CSUM);
  assign imem_we    = (r_state == WRITE) && w_word_full;
  assign imem_addr  = r_addr;
  assign imem_wdata = w_word;
  assign cpu_reset  = (r_state != DONE);
  assign load_done  = (r_state == DONE);
  assign load_err   = (r_state == ERR);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized self-checking bench for imem_boot_loader against a frame-level model.
module tb_imem_boot_loader;

  localparam int unsigned TB_ADDR_W = 8;
  localparam int unsigned TB_BASE   = 0;

  logic                 CLK = 1'b0;
  logic                 Reset = 1'b1;
  logic                 rx_valid = 1'b0;
  logic [7:0]           rx_data = '0;
  logic                 rx_ready;
  logic                 imem_we;
  logic [TB_ADDR_W-1:0] imem_addr;
  logic [31:0]          imem_wdata;
  logic                 cpu_reset;
  logic                 load_done;
  logic                 load_err;

  imem_boot_loader #(.ADDR_W(TB_ADDR_W), .BASE_ADDR(TB_BASE)) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 CLK = ~CLK;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [31:0] exp_words[$];
  logic [7:0]  frame_q[$];

  int          cyc = 0;
  bit          mon_en = 1'b0;
  int          acc_cyc[$];
  logic [7:0]  acc_byte[$];
  int          we_cyc[$];
  logic [31:0] we_addr[$];
  logic [31:0] we_data[$];
  int          done_cyc = -1;
  int          err_cyc  = -1;

  always @(posedge CLK) cyc <= cyc + 1;

  // Observe every cycle midway through the low phase.
  always begin
    @(negedge CLK);
    #3;
    if (mon_en) begin
      if (rx_valid && rx_ready) begin
        acc_cyc.push_back(cyc);
        acc_byte.push_back(rx_data);
      end
      if (imem_we) begin
        we_cyc.push_back(cyc);
        we_addr.push_back(32'(imem_addr));
        we_data.push_back(imem_wdata);
      end
      if (load_done && done_cyc < 0) done_cyc = cyc;
      if (load_err && err_cyc < 0)   err_cyc  = cyc;
      if (!load_done && !load_err)
        check_eq("ready_vs_write", 32'(rx_ready), 32'(!imem_we));
    end
  end

  task automatic do_reset();
    @(negedge CLK);
    mon_en   = 1'b0;
    rx_valid = 1'b0;
    Reset    = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check_eq("rst_rx_ready",  32'(rx_ready), 32'd1);
    check_eq("rst_we",        32'(imem_we), 32'd0);
    check_eq("rst_addr",      32'(imem_addr), TB_BASE);
    check_eq("rst_wdata",     imem_wdata, 32'd0);
    check_eq("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check_eq("rst_done",      32'(load_done), 32'd0);
    check_eq("rst_err",       32'(load_err), 32'd0);
    Reset = 1'b0;
    acc_cyc.delete();
    acc_byte.delete();
    we_cyc.delete();
    we_addr.delete();
    we_data.delete();
    done_cyc = -1;
    err_cyc  = -1;
    mon_en   = 1'b1;
  endtask

  task automatic gen_words(input int unsigned n);
    exp_words.delete();
    for (int unsigned i = 0; i < n; i++) exp_words.push_back($urandom);
  endtask

  // Reference framing: count, big-endian words, XOR of everything before it.
  task automatic build_frame();
    int unsigned n;
    logic [7:0]  cs;
    logic [31:0] w;
    n = exp_words.size();
    frame_q.delete();
    frame_q.push_back(n[15:8]);
    frame_q.push_back(n[7:0]);
    foreach (exp_words[i]) begin
      w = exp_words[i];
      frame_q.push_back(w[31:24]);
      frame_q.push_back(w[23:16]);
      frame_q.push_back(w[15:8]);
      frame_q.push_back(w[7:0]);
    end
    cs = '0;
    foreach (frame_q[i]) cs = cs ^ frame_q[i];
    frame_q.push_back(cs);
  endtask

  task automatic send_frame(input int unsigned max_gap);
    int unsigned gap;
    int unsigned t;
    foreach (frame_q[i]) begin
      gap = $urandom_range(max_gap, 0);
      t   = 0;
      if (gap > 0) begin
        rx_valid = 1'b0;
        repeat (gap) @(negedge CLK);
      end
      rx_valid = 1'b1;
      rx_data  = frame_q[i];
      while (!rx_ready && t < 20) begin
        @(negedge CLK);
        t++;
      end
      if (!rx_ready) begin
        check_eq("accept_timeout", 32'(rx_ready), 32'd1);
        rx_valid = 1'b0;
        return;
      end
      @(negedge CLK);
    end
    rx_valid = 1'b0;
  endtask

  task automatic offer_junk();
    repeat (6) begin
      rx_valid = 1'b1;
      rx_data  = 8'($urandom);
      @(negedge CLK);
    end
    rx_valid = 1'b0;
  endtask

  task automatic verify(input bit exp_ok, input int unsigned n_acc, input bit gapless);
    int last;
    int unsigned k;
    repeat (3) @(negedge CLK);
    #4;
    check_eq("n_accepted", acc_cyc.size(), n_acc);
    for (int unsigned i = 0; i < n_acc && i < acc_byte.size(); i++)
      check_eq("accepted_byte", 32'(acc_byte[i]), 32'(frame_q[i]));
    check_eq("n_writes", we_addr.size(), exp_words.size());
    for (int unsigned j = 0; j < exp_words.size() && j < we_addr.size(); j++) begin
      check_eq("wr_addr", we_addr[j], (TB_BASE + j) % (1 << TB_ADDR_W));
      check_eq("wr_data", we_data[j], exp_words[j]);
      k = 2 + 4 * j + 3;
      if (k < acc_cyc.size()) check_eq("wr_latency", we_cyc[j], acc_cyc[k] + 1);
      if (gapless && j > 0)   check_eq("wr_spacing", we_cyc[j] - we_cyc[j-1], 32'd5);
    end
    last = (acc_cyc.size() > 0) ? acc_cyc[acc_cyc.size()-1] : -100;
    check_eq("end_rx_ready", 32'(rx_ready), 32'd0);
    if (exp_ok) begin
      check_eq("done",        32'(load_done), 32'd1);
      check_eq("err",         32'(load_err), 32'd0);
      check_eq("cpu_reset",   32'(cpu_reset), 32'd0);
      check_eq("done_timing", done_cyc, last + 1);
    end else begin
      check_eq("done",       32'(load_done), 32'd0);
      check_eq("err",        32'(load_err), 32'd1);
      check_eq("cpu_reset",  32'(cpu_reset), 32'd1);
      check_eq("err_timing", err_cyc, last + 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // Fixed two-word frame, continuous valid.
    do_reset();
    exp_words.delete();
    exp_words.push_back(32'h12345678);
    exp_words.push_back(32'h9ABCDEF0);
    build_frame();
    send_frame(0);
    verify(1'b1, frame_q.size(), 1'b1);

    // Same frame with idle gaps.
    do_reset();
    build_frame();
    send_frame(3);
    verify(1'b1, frame_q.size(), 1'b0);

    // Empty image.
    do_reset();
    exp_words.delete();
    build_frame();
    send_frame(0);
    verify(1'b1, 3, 1'b0);

    // Corrupted checksum: words still land, then error and nothing more accepted.
    do_reset();
    gen_words(3);
    build_frame();
    frame_q[frame_q.size()-1] = frame_q[frame_q.size()-1] ^ 8'h01;
    send_frame(1);
    offer_junk();
    verify(1'b0, frame_q.size(), 1'b0);

    // Oversize count 257.
    do_reset();
    exp_words.delete();
    frame_q.delete();
    frame_q.push_back(8'h01);
    frame_q.push_back(8'h01);
    send_frame(0);
    offer_junk();
    verify(1'b0, 2, 1'b0);

    // Reset partway through a word, then a clean frame.
    do_reset();
    frame_q.delete();
    frame_q.push_back(8'h00);
    frame_q.push_back(8'h01);
    frame_q.push_back(8'hAB);
    frame_q.push_back(8'hCD);
    send_frame(0);
    do_reset();
    gen_words(2);
    build_frame();
    send_frame(2);
    verify(1'b1, frame_q.size(), 1'b0);

    // Random images with random gaps.
    for (int unsigned r = 0; r < 6; r++) begin
      do_reset();
      gen_words($urandom_range(8, 1));
      build_frame();
      send_frame($urandom_range(3, 0));
      verify(1'b1, frame_q.size(), 1'b0);
    end

    // Exactly full capacity.
    do_reset();
    gen_words(1 << TB_ADDR_W);
    build_frame();
    send_frame(0);
    verify(1'b1, frame_q.size(), 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
